// File: rtl/stream_pkg.sv
// Shared definitions for the 32-bit word to byte-stream serializer:
// FSM state encoding, datapath widths and byte-lane select constants.
package stream_pkg;

    // IDLE: no word held. SEND: word held with bytes still pending.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    // Byte lanes of the 32-bit word: lane 0 is bits 7:0, lane 3 is bits 31:24.
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    // Map the running byte index onto the lane to emit, by transmit order.
    function automatic logic [1:0] lane_sel(input logic [1:0] idx, input logic msb_first);
        logic [1:0] lane;
        if (msb_first) begin
            lane = LANE_B3 - idx;
        end else begin
            lane = LANE_B0 + idx;
        end
        return lane;
    endfunction

endpackage

// File: rtl/stream_serializer.sv
// Word-to-byte serializer: accepts a 32-bit word with a 1..4 byte length and
// emits its bytes one per cycle on a valid/ready byte stream, with the last
// byte flagged. The upstream side is re-opened on the cycle the last byte
// leaves, so consecutive words stream without a bubble.
module stream_serializer
    import stream_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid_i,
    input  logic [WORD_W-1:0]   i_data_i,
    input  logic [1:0]          i_len_i,
    output logic                i_ready_o,
    input  logic                e_ready_i,
    output logic                e_valid_o,
    output logic [BYTE_W-1:0]   e_data_o,
    output logic                e_last_o
);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q,  word_d;
    logic [1:0]          len_q,   len_d;
    logic [1:0]          idx_q,   idx_d;
    logic [1:0]          lane;
    logic                word_xfer;
    logic                byte_xfer;

    // Stream outputs depend only on held registers, never on upstream inputs.
    assign e_valid_o = (state_q == SEND);
    assign e_last_o  = (state_q == SEND) && (idx_q == len_q);
    assign byte_xfer = e_valid_o && e_ready_i;

    // Upstream may load a new word when empty or as the final byte departs.
    assign i_ready_o = (state_q == IDLE) || (byte_xfer && e_last_o);
    assign word_xfer = i_valid_i && i_ready_o;

    // Byte-lane mux selecting the current byte out of the held word.
    always_comb begin
        lane = lane_sel(idx_q, MSB_FIRST);
        e_data_o = '0;
        case (lane)
            LANE_B0: e_data_o = word_q[7:0];
            LANE_B1: e_data_o = word_q[15:8];
            LANE_B2: e_data_o = word_q[23:16];
            LANE_B3: e_data_o = word_q[31:24];
            default: e_data_o = '0;
        endcase
    end

    // Next-state logic: load on word transfer, step the index per byte sent.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        word_d  = word_q;
        len_d   = len_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (word_xfer) begin
                    state_d = SEND;
                    word_d  = i_data_i;
                    len_d   = i_len_i;
                    idx_d   = 2'd0;
                end
            end
            SEND: begin
                if (byte_xfer) begin
                    if (e_last_o) begin
                        if (word_xfer) begin
                            state_d = SEND;
                            word_d  = i_data_i;
                            len_d   = i_len_i;
                            idx_d   = 2'd0;
                        end else begin
                            state_d = IDLE;
                            idx_d   = 2'd0;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // State and datapath registers; reset empties the serializer at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the held word is a plain register, so it is cleared on reset like the rest; a reset byte therefore reads as 8'h00.
            state_q <= IDLE;
            word_q  <= '0;
            len_q   <= 2'd0;
            idx_q   <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
            state_q <= state_d;
            word_q  <= word_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Directed self-checking bench for stream_serializer. Two instances share all
// inputs: one sends MSB first, the other LSB first. Expected bytes are hand
// computed from the stimulus words.
module tb_stream_serializer;

    logic        clk;
    logic        reset;
    logic        i_valid_i;
    logic [31:0] i_data_i;
    logic [1:0]  i_len_i;
    logic        e_ready_i;

    logic        m_i_ready, m_e_valid, m_e_last;
    logic [7:0]  m_e_data;
    logic        l_i_ready, l_e_valid, l_e_last;
    logic [7:0]  l_e_data;

    int errors = 0;
    int checks = 0;

    stream_serializer #(.MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .reset     (reset),
        .i_valid_i (i_valid_i),
        .i_data_i  (i_data_i),
        .i_len_i   (i_len_i),
        .i_ready_o (m_i_ready),
        .e_ready_i (e_ready_i),
        .e_valid_o (m_e_valid),
        .e_data_o  (m_e_data),
        .e_last_o  (m_e_last)
    );

    stream_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .i_valid_i (i_valid_i),
        .i_data_i  (i_data_i),
        .i_len_i   (i_len_i),
        .i_ready_o (l_i_ready),
        .e_ready_i (e_ready_i),
        .e_valid_o (l_e_valid),
        .e_data_o  (l_e_data),
        .e_last_o  (l_e_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all four stream-side outputs of the MSB-first instance.
    task automatic check_m(input string tag, input logic v, input logic [7:0] d,
                           input logic last, input logic rdy);
        check({tag, " m_valid"}, 32'(m_e_valid), 32'(v));
        if (v) check({tag, " m_data"}, 32'(m_e_data), 32'(d));
        check({tag, " m_last"}, 32'(m_e_last), 32'(last));
        check({tag, " m_ready"}, 32'(m_i_ready), 32'(rdy));
    endtask

    // Check byte and last flag of the LSB-first instance.
    task automatic check_l(input string tag, input logic [7:0] d, input logic last);
        check({tag, " l_valid"}, 32'(l_e_valid), 32'd1);
        check({tag, " l_data"}, 32'(l_e_data), 32'(d));
        check({tag, " l_last"}, 32'(l_e_last), 32'(last));
    endtask

    logic [7:0] seq [8];

    initial begin
        reset     = 1'b0;
        i_valid_i = 1'b0;
        i_data_i  = '0;
        i_len_i   = 2'd0;
        e_ready_i = 1'b1;

        // Reset state.
        #2;
        check("rst m_valid", 32'(m_e_valid), 32'd0);
        check("rst m_data",  32'(m_e_data),  32'h00);
        check("rst m_last",  32'(m_e_last),  32'd0);
        check("rst m_ready", 32'(m_i_ready), 32'd1);
        check("rst l_valid", 32'(l_e_valid), 32'd0);
        tick();
        tick();
        reset = 1'b1;

        // Four bytes, full throughput; word offered on first edge after release.
        i_valid_i = 1'b1; i_data_i = 32'hA1B2C3D4; i_len_i = 2'd3;
        tick();
        i_valid_i = 1'b0; i_data_i = 32'hDEADBEEF; i_len_i = 2'd0;
        check_m("w4 b0", 1'b1, 8'hA1, 1'b0, 1'b0);
        check_l("w4 b0", 8'hD4, 1'b0);
        tick();
        check_m("w4 b1", 1'b1, 8'hB2, 1'b0, 1'b0);
        check_l("w4 b1", 8'hC3, 1'b0);
        tick();
        check_m("w4 b2", 1'b1, 8'hC3, 1'b0, 1'b0);
        check_l("w4 b2", 8'hB2, 1'b0);
        tick();
        check_m("w4 b3", 1'b1, 8'hD4, 1'b1, 1'b1);
        check_l("w4 b3", 8'hA1, 1'b1);
        tick();
        check_m("w4 idle", 1'b0, 8'h00, 1'b0, 1'b1);

        // Two bytes.
        i_valid_i = 1'b1; i_data_i = 32'hA1B2C3D4; i_len_i = 2'd1;
        tick();
        i_valid_i = 1'b0;
        check_m("w2 b0", 1'b1, 8'hA1, 1'b0, 1'b0);
        check_l("w2 b0", 8'hD4, 1'b0);
        tick();
        check_m("w2 b1", 1'b1, 8'hB2, 1'b1, 1'b1);
        check_l("w2 b1", 8'hC3, 1'b1);
        tick();
        check_m("w2 idle", 1'b0, 8'h00, 1'b0, 1'b1);
        check("w2 idle l_valid", 32'(l_e_valid), 32'd0);

        // Three bytes, both orders.
        i_valid_i = 1'b1; i_data_i = 32'hCAFEBABE; i_len_i = 2'd2;
        tick();
        i_valid_i = 1'b0;
        check_m("w3 b0", 1'b1, 8'hCA, 1'b0, 1'b0);
        check_l("w3 b0", 8'hBE, 1'b0);
        tick();
        check_m("w3 b1", 1'b1, 8'hFE, 1'b0, 1'b0);
        check_l("w3 b1", 8'hBA, 1'b0);
        tick();
        check_m("w3 b2", 1'b1, 8'hBA, 1'b1, 1'b1);
        check_l("w3 b2", 8'hFE, 1'b1);
        tick();
        check_m("w3 idle", 1'b0, 8'h00, 1'b0, 1'b1);

        // Back-to-back words: eight bytes on eight consecutive cycles.
        seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03; seq[3] = 8'h04;
        seq[4] = 8'h05; seq[5] = 8'h06; seq[6] = 8'h07; seq[7] = 8'h08;
        i_valid_i = 1'b1; i_data_i = 32'h01020304; i_len_i = 2'd3;
        tick();
        i_data_i = 32'h05060708;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) i_valid_i = 1'b0;
            check_m($sformatf("b2b k%0d", k), 1'b1, seq[k], (k == 3 || k == 7),
                    (k == 3 || k == 7));
            tick();
        end
        check_m("b2b idle", 1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure during B2, with ignored junk offered upstream.
        i_valid_i = 1'b1; i_data_i = 32'hA1B2C3D4; i_len_i = 2'd3;
        tick();
        i_valid_i = 1'b1; i_data_i = 32'hFFFFFFFF; i_len_i = 2'd0;
        check_m("bp b0", 1'b1, 8'hA1, 1'b0, 1'b0);
        tick();
        e_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_m($sformatf("bp stall c%0d", c), 1'b1, 8'hB2, 1'b0, 1'b0);
            check_l($sformatf("bp stall c%0d", c), 8'hC3, 1'b0);
            tick();
        end
        i_valid_i = 1'b0;
        e_ready_i = 1'b1;
        check_m("bp release", 1'b1, 8'hB2, 1'b0, 1'b0);
        tick();
        check_m("bp b2", 1'b1, 8'hC3, 1'b0, 1'b0);
        tick();
        check_m("bp b3", 1'b1, 8'hD4, 1'b1, 1'b1);
        tick();
        check_m("bp idle", 1'b0, 8'h00, 1'b0, 1'b1);

        // Reset mid-word after A1 has been sent.
        i_valid_i = 1'b1; i_data_i = 32'hA1B2C3D4; i_len_i = 2'd3;
        tick();
        i_valid_i = 1'b0;
        check_m("mid b0", 1'b1, 8'hA1, 1'b0, 1'b0);
        tick();
        check_m("mid b1", 1'b1, 8'hB2, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("mid rst m_valid", 32'(m_e_valid), 32'd0);
        check("mid rst m_data",  32'(m_e_data),  32'h00);
        check("mid rst m_last",  32'(m_e_last),  32'd0);
        tick();
        reset = 1'b1;
        #1;
        check_m("post rst", 1'b0, 8'h00, 1'b0, 1'b1);
        i_valid_i = 1'b1; i_data_i = 32'h11223344; i_len_i = 2'd0;
        tick();
        i_valid_i = 1'b0;
        check_m("len0", 1'b1, 8'h11, 1'b1, 1'b1);
        check_l("len0", 8'h44, 1'b1);
        tick();
        check_m("len0 idle", 1'b0, 8'h00, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_serializer.md
STREAM_SERIALIZER -- requirements
Module: stream_serializer

Interface
REQ-001 Parameter MSB_FIRST, default 1: 1 = byte 3 (bits 31:24) sent first; 0 = byte 0 (bits 7:0) sent first.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 i_valid_i  input  1  upstream word valid.
REQ-005 i_data_i  input  32  upstream word.
REQ-006 i_len_i  input  2  number of bytes in the word minus 1 (0 = 1 byte ... 3 = 4 bytes).
REQ-007 i_ready_o  output  1  serializer can accept a word this cycle.
REQ-008 e_ready_i  input  1  downstream byte sink ready (e.g. skid_buffer i_ready_o).
REQ-009 e_valid_o  output  1  byte valid toward downstream.
REQ-010 e_data_o  output  8  current byte.
REQ-011 e_last_o  output  1  marks the final byte of the current word.

Function
REQ-012 A word transfer SHALL occur on a cycle where i_valid_i && i_ready_o; a byte transfer SHALL occur where e_valid_o && e_ready_i.
REQ-013 States SHALL be IDLE (no word held) and SEND (word held, bytes pending).
REQ-014 IDLE -> SEND on word transfer; SEND -> IDLE on byte transfer with e_last_o=1 and no new word transfer; SEND -> SEND on last-byte transfer coinciding with a new word transfer.
REQ-015 i_ready_o SHALL equal (state==IDLE) || (e_valid_o && e_ready_i && e_last_o); no other combinational path to i_ready_o.
REQ-016 On word transfer, word, length and byte index (0) SHALL be registered; first byte appears on e_data_o the next cycle (latency 1 cycle).
REQ-017 e_valid_o, e_data_o, e_last_o SHALL be driven only from registers (no combinational path from i_* inputs).
REQ-018 Byte k of the word (k = 0..len) SHALL be bits [31-8k:24-8k] when MSB_FIRST=1, bits [8k+7:8k] when MSB_FIRST=0.
REQ-019 e_last_o SHALL be 1 exactly when byte index == held length.
REQ-020 While e_valid_o=1 and e_ready_i=0, e_data_o and e_last_o SHALL hold stable; byte index SHALL not advance.
REQ-021 Byte index (2 bits) SHALL advance by 1 per non-last byte transfer; it never wraps past the held length.
REQ-022 Back-to-back words SHALL stream with no idle cycle: sustained throughput one byte per cycle when e_ready_i=1.
REQ-023 i_len_i=0 words SHALL produce a single byte with e_last_o=1.
REQ-024 Inputs i_data_i/i_len_i SHALL be ignored when no word transfer occurs.

Reset
REQ-025 Reset asserted SHALL immediately force state IDLE, e_valid_o=0, e_data_o=8'h00, e_last_o=0, byte index 0, held word 0, held length 0.
REQ-026 Reset mid-word SHALL discard remaining bytes; after release, i_ready_o=1 and no stale byte is emitted.
REQ-027 First word transfer is permitted on the first rising edge after reset release.

Structure
REQ-028 State encoding (IDLE, SEND) and byte-lane select constants SHALL live in a shared package stream_pkg.
REQ-029 Single module; no sub-modules — byte-lane mux is inline.
REQ-030 Output SHALL connect directly to skid_buffer i_valid_i/i_data_i/i_ready_o without glue logic.

Verification
REQ-031 MSB_FIRST=1, word 32'hA1B2C3D4 len 3, e_ready_i=1 -> bytes A1,B2,C3,D4 on 4 consecutive cycles, e_last_o only with D4.
REQ-032 MSB_FIRST=0, same word len 1 -> bytes D4,C3, e_last_o with C3, then IDLE with e_valid_o=0.
REQ-033 Two back-to-back len-3 words 32'h01020304, 32'h05060708, e_ready_i=1 -> 8 bytes 01..08 on 8 consecutive cycles, i_ready_o=1 in the cycle 04 is accepted.
REQ-034 e_ready_i held 0 for 5 cycles during byte B2 -> e_data_o=B2 stable, i_ready_o=0 throughout; stream resumes with C3 after e_ready_i=1.
REQ-035 reset asserted after A1 sent -> e_valid_o=0 immediately; after release word 32'h11223344 len 0 -> single byte 11 with e_last_o=1.
REQ-036 Random backpressure, 1000 words, connected to skid_buffer -> scoreboard byte sequence matches exactly, no drop or duplicate.
